// File: rtl/memory_responder.sv
// memory_responder: big-endian byte-addressable RAM answering MOV requests with MOC after WAIT_CYCLES.
module memory_responder #(
   parameter int ADDR_WIDTH  = 8,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        MOV,
   input  logic        RW,
   input  logic [1:0]  DS,
   input  logic [31:0] ADDR,
   input  logic [31:0] DATA_IN,
   output logic [31:0] DATA_OUT,
   output logic        MOC,
   output logic        ERR,
   output logic        BUSY
);
   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
   state_t state_q, state_d;
   logic [7:0] mem [2**ADDR_WIDTH];
   logic rw_q;
   logic [1:0] ds_q;
   logic [ADDR_WIDTH-1:0] addr_q, a1, a2, a3;
   logic [31:0] wdata_q, rdata;
   logic [3:0] cnt_q;
   logic access, fault, we, unused_addr;
   assign unused_addr = ^ADDR[31:ADDR_WIDTH];
   assign a1 = addr_q + ADDR_WIDTH'(1);
   assign a2 = addr_q + ADDR_WIDTH'(2);
   assign a3 = addr_q + ADDR_WIDTH'(3);
   assign access = state_q == WAIT && cnt_q == 4'(WAIT_CYCLES);
   assign fault = ds_q == 2'b11 || (ds_q == 2'b01 && addr_q[0]) || (ds_q == 2'b10 && addr_q[1:0] != 2'b00);
   assign we = access && !rw_q && !fault && !RESET;
   assign BUSY = state_q != IDLE;
   assign rdata = ds_q == 2'b10 ? {mem[addr_q], mem[a1], mem[a2], mem[a3]} :
                  ds_q == 2'b01 ? {16'b0, mem[addr_q], mem[a1]} : {24'b0, mem[addr_q]};
   always_comb begin
      state_d = (state_q == IDLE && MOV) ? WAIT :
                access ? DONE :
                (state_q == DONE && !MOV) ? IDLE : state_q;
   end
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q  <= IDLE;
         MOC      <= 1'b0;
         ERR      <= 1'b0;
         DATA_OUT <= '0;
         cnt_q    <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && MOV) begin
            rw_q    <= RW;
            ds_q    <= DS;
            addr_q  <= ADDR[ADDR_WIDTH-1:0];
            wdata_q <= DATA_IN;
            ERR     <= 1'b0;
            cnt_q   <= '0;
         end
         if (state_q == WAIT && !access) cnt_q <= cnt_q + 4'd1;
         if (access) begin
            MOC <= 1'b1;
            ERR <= fault;
            if (rw_q && !fault) DATA_OUT <= rdata;
         end
         if (state_q == DONE && !MOV) begin
            MOC <= 1'b0;
            ERR <= 1'b0;
         end
      end
   end
   // Array has no reset; a write is squashed when reset coincides with the access edge.
   always_ff @(posedge CLK) begin
      if (we) begin
         if (ds_q == 2'b10) begin
            mem[addr_q] <= wdata_q[31:24];
            mem[a1]     <= wdata_q[23:16];
            mem[a2]     <= wdata_q[15:8];
            mem[a3]     <= wdata_q[7:0];
         end else if (ds_q == 2'b01) begin
            mem[addr_q] <= wdata_q[15:8];
            mem[a1]     <= wdata_q[7:0];
         end else begin
            mem[addr_q] <= wdata_q[7:0];
         end
      end
   end
endmodule

// File: tb/tb_memory_responder.sv
// tb_memory_responder: vector table plus handshake/reset sequences, scoreboarded completions.
module tb_memory_responder;
   localparam int WC = 2;
   logic        CLK = 1'b0, RESET, MOV, RW;
   logic [1:0]  DS;
   logic [31:0] ADDR, DATA_IN, DATA_OUT;
   logic        MOC, ERR, BUSY;
   int checks = 0, fails = 0;
   typedef struct {logic rw; logic [1:0] ds; logic [31:0] addr; logic [31:0] data; logic err;} vec_t;
   typedef struct {logic err; logic [31:0] dout;} exp_t;
   exp_t sb[$];
   logic [31:0] last_dout;
   vec_t vecs[16];
   vec_t v;

   memory_responder #(.ADDR_WIDTH(8), .WAIT_CYCLES(WC)) dut (
      .CLK(CLK), .RESET(RESET), .MOV(MOV), .RW(RW), .DS(DS), .ADDR(ADDR),
      .DATA_IN(DATA_IN), .DATA_OUT(DATA_OUT), .MOC(MOC), .ERR(ERR), .BUSY(BUSY)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic do_req(input vec_t t, input int hold, input bit drop_early);
      int n;
      exp_t e;
      @(negedge CLK);
      MOV = 1'b1; RW = t.rw; DS = t.ds; ADDR = t.addr; DATA_IN = t.data;
      e.err = t.err;
      e.dout = (t.rw && !t.err) ? t.data : last_dout;
      last_dout = e.dout;
      sb.push_back(e);
      n = 0;
      do begin
         @(posedge CLK); #1;
         n++;
         if (drop_early) MOV = 1'b0;
         if (n == 1) check("busy_after_accept", {31'b0, BUSY}, 32'd1);
      end while (!MOC && n < 30);
      check("moc_latency", n, WC + 2);
      e = sb.pop_front();
      check("err", {31'b0, ERR}, {31'b0, e.err});
      check("data_out", DATA_OUT, e.dout);
      repeat (hold) begin
         @(posedge CLK); #1;
         check("moc_held", {31'b0, MOC}, 32'd1);
      end
      MOV = 1'b0;
      @(posedge CLK); #1;
      check("moc_fall", {31'b0, MOC}, 32'd0);
      check("err_fall", {31'b0, ERR}, 32'd0);
      check("busy_fall", {31'b0, BUSY}, 32'd0);
      check("dout_hold", DATA_OUT, e.dout);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vecs[0]  = '{1'b0, 2'b10, 32'h10,  32'hDEADBEEF, 1'b0};
      vecs[1]  = '{1'b1, 2'b00, 32'h10,  32'h000000DE, 1'b0};
      vecs[2]  = '{1'b1, 2'b00, 32'h13,  32'h000000EF, 1'b0};
      vecs[3]  = '{1'b0, 2'b01, 32'h12,  32'h00001234, 1'b0};
      vecs[4]  = '{1'b1, 2'b10, 32'h10,  32'hDEAD1234, 1'b0};
      vecs[5]  = '{1'b0, 2'b00, 32'h11,  32'h00000055, 1'b0};
      vecs[6]  = '{1'b1, 2'b10, 32'h10,  32'hDE551234, 1'b0};
      vecs[7]  = '{1'b1, 2'b10, 32'h02,  32'h00000000, 1'b1};
      vecs[8]  = '{1'b0, 2'b10, 32'h20,  32'hA5A5A5A5, 1'b0};
      vecs[9]  = '{1'b0, 2'b01, 32'h21,  32'h0000FFFF, 1'b1};
      vecs[10] = '{1'b0, 2'b11, 32'h20,  32'hFFFFFFFF, 1'b1};
      vecs[11] = '{1'b1, 2'b10, 32'h20,  32'hA5A5A5A5, 1'b0};
      vecs[12] = '{1'b1, 2'b01, 32'h22,  32'h0000A5A5, 1'b0};
      vecs[13] = '{1'b0, 2'b10, 32'h1FC, 32'h01020304, 1'b0};
      vecs[14] = '{1'b1, 2'b10, 32'hFC,  32'h01020304, 1'b0};
      vecs[15] = '{1'b0, 2'b10, 32'h40,  32'h11223344, 1'b0};
      RESET = 1'b1; MOV = 1'b0; RW = 1'b0; DS = 2'b00; ADDR = '0; DATA_IN = '0;
      last_dout = '0;
      repeat (3) @(posedge CLK);
      #1;
      check("reset_moc", {31'b0, MOC}, 32'd0);
      check("reset_err", {31'b0, ERR}, 32'd0);
      check("reset_busy", {31'b0, BUSY}, 32'd0);
      check("reset_dout", DATA_OUT, 32'd0);
      RESET = 1'b0;
      foreach (vecs[i]) do_req(vecs[i], 0, 1'b0);
      // MOV held five cycles past MOC
      v = '{1'b1, 2'b10, 32'h10, 32'hDE551234, 1'b0};
      do_req(v, 5, 1'b0);
      // MOV dropped right after acceptance: access completes, MOC one cycle
      v = '{1'b1, 2'b00, 32'h13, 32'h00000034, 1'b0};
      do_req(v, 0, 1'b1);
      // reset during WAIT discards the write
      @(negedge CLK);
      MOV = 1'b1; RW = 1'b0; DS = 2'b10; ADDR = 32'h40; DATA_IN = 32'hCAFEF00D;
      @(posedge CLK); #1;
      @(posedge CLK); #1;
      check("busy_in_wait", {31'b0, BUSY}, 32'd1);
      RESET = 1'b1; MOV = 1'b0;
      @(posedge CLK); #1;
      check("midwait_reset_moc", {31'b0, MOC}, 32'd0);
      check("midwait_reset_err", {31'b0, ERR}, 32'd0);
      check("midwait_reset_dout", DATA_OUT, 32'd0);
      check("midwait_reset_busy", {31'b0, BUSY}, 32'd0);
      RESET = 1'b0;
      last_dout = '0;
      repeat (4) @(posedge CLK);
      check("no_stray_moc", {31'b0, MOC}, 32'd0);
      v = '{1'b1, 2'b10, 32'h40, 32'h11223344, 1'b0};
      do_req(v, 0, 1'b0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
